vga_fb_arbiter: RTL and testbench

Framebuffer access scheduler between the VGA sync generator and a single-port framebuffer RAM. Fixed time-division rule: the display fetch owns one reserved read slot per 16-pixel word, one word ahead of the beam. All remaining cycles go to a pixel-writer port with a req/ack handshake. The block also holds the 16-bit display shift register and drives the monochrome pixel stream.

---
 rtl/vga_fb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_vga_fb_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fb_arbiter.sv
// Framebuffer slot scheduler: display prefetch, optional clear engine, writer port.
// Define FB_CLEAR_EN to build the clear engine and its clr_* ports.
module vga_fb_arbiter #(
    parameter int H_DISPLAY = 640,
    parameter int H_TOTAL   = 800,
    parameter int V_DISPLAY = 480,
    parameter int V_TOTAL   = 524,
    parameter int WPL       = 40,
    parameter int AW        = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [9:0]    hpos,
    input  logic [9:0]    vpos,
    input  logic          display_on,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [15:0]   mem_wdata,
    input  logic [15:0]   mem_rdata,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [15:0]   wr_data,
    output logic          wr_ack,
`ifdef FB_CLEAR_EN
    input  logic          clr_start,
    input  logic [15:0]   clr_data,
    output logic          clr_busy,
`endif
    output logic          pix_out
);

    localparam int FB_WORDS = V_DISPLAY * WPL;

    localparam logic [9:0] HD        = 10'(H_DISPLAY);
    localparam logic [9:0] HD_LAST   = 10'(H_DISPLAY - 1);
    localparam logic [9:0] HT_PRE    = 10'(H_TOTAL - 16);
    localparam logic [9:0] HT_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] VD        = 10'(V_DISPLAY);
    localparam logic [9:0] VT_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] FETCH_END = 10'((WPL - 1) * 16);

    localparam logic [AW-1:0] FBW     = AW'(FB_WORDS);
    localparam logic [AW-1:0] FB_LAST = AW'(FB_WORDS - 1);

    // line * 40 without a multiplier
    function automatic logic [AW-1:0] line_base(input logic [9:0] l);
        return AW'({l, 5'b0}) + AW'({l, 3'b0});
    endfunction

    logic [9:0]    next_line;
    logic          slot_word;
    logic          slot_line;
    logic          slot;
    logic [AW-1:0] fetch_addr;
    logic          busy;
    logic          clr_go;
    logic [AW-1:0] clr_waddr;
    logic [15:0]   clr_wdata;

    logic          slot_d;
    logic [15:0]   next_word;
    logic [15:0]   sr;
    logic          load;

    assign next_line = (vpos == VT_LAST) ? 10'd0 : vpos + 10'd1;

    assign slot_word = reset && (hpos[3:0] == 4'd0)
                     && (hpos < FETCH_END) && (vpos < VD);
    assign slot_line = reset && (hpos == HT_PRE) && (next_line < VD);
    assign slot      = slot_word | slot_line;

    assign fetch_addr = slot_line ? line_base(next_line)
                      : line_base(vpos) + AW'(hpos[9:4]) + AW'(1);

`ifdef FB_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} clr_state_t;

    clr_state_t    state;
    logic [AW-1:0] clr_ptr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            clr_ptr  <= '0;
            clr_busy <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_ptr  <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (!slot) begin
                        clr_ptr <= clr_ptr + AW'(1);
                        if (clr_ptr == FB_LAST) begin
                            state    <= IDLE;
                            clr_busy <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    assign busy      = clr_busy;
    assign clr_go    = reset & clr_busy & ~slot;
    assign clr_waddr = clr_ptr;
    assign clr_wdata = clr_data;
`else
    assign busy      = 1'b0;
    assign clr_go    = 1'b0;
    assign clr_waddr = '0;
    assign clr_wdata = '0;
`endif

    assign wr_ack = wr_req & ~slot & ~busy & reset;

    // Out-of-range writer addresses are acked but never strobed.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (slot) begin
            mem_addr = fetch_addr;
        end else if (clr_go) begin
            mem_addr  = clr_waddr;
            mem_we    = 1'b1;
            mem_wdata = clr_wdata;
        end else if (wr_ack) begin
            mem_addr  = wr_addr;
            mem_we    = (wr_addr < FBW);
            mem_wdata = wr_data;
        end
    end

    assign load = ((hpos[3:0] == 4'hF) && (hpos < HD_LAST))
                || (hpos == HT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_d    <= 1'b0;
            next_word <= '0;
            sr        <= '0;
        end else begin
            slot_d <= slot;
            if (slot_d) begin
                next_word <= mem_rdata;
            end
            if (load) begin
                sr <= next_word;
            end else if (hpos < HD) begin
                sr <= {sr[14:0], 1'b0};
            end
        end
    end

    assign pix_out = sr[15] & display_on & reset;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: vector table, corner sequences, random writes vs frame model.
// Define FB_CLEAR_EN to also exercise the clear engine.
`timescale 1ns/1ps
module tb_vga_fb_arbiter;

    localparam int AW  = 15;
    localparam int FBW = 19200;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    hpos;
    logic [9:0]    vpos;
    logic          display_on;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_ack;
    logic          pix_out;
`ifdef FB_CLEAR_EN
    logic          clr_start;
    logic [15:0]   clr_data;
    logic          clr_busy;
`endif

    always #5 clk = ~clk;

    vga_fb_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
`ifdef FB_CLEAR_EN
        .clr_start  (clr_start),
        .clr_data   (clr_data),
        .clr_busy   (clr_busy),
`endif
        .pix_out    (pix_out)
    );

    // Single-port RAM, read data one cycle after the address
    bit [15:0] ram [0:32767];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    bit [15:0]     fb [0:FBW-1];
    int            total = 0;
    int            bad = 0;
    int            cur_h = 0;
    int            cur_v = 0;
    bit            w_pend = 0;
    logic [AW-1:0] w_addr_q = '0;
    logic [15:0]   w_data_q = '0;
    bit            w_rand = 0;
    bit            chk_pix = 0;
    bit            exp_busy = 0;
    int            exp_ptr = 0;
    bit            clr_pulse = 0;
    logic [15:0]   clr_val = 16'hFFFF;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at v=%0d h=%0d: got %0h want %0h",
                     nm, cur_v, cur_h, act, exp);
        end
    endtask

    function automatic int exp_fetch(input int h, input int v);
        int l;
        if (v < 480 && h % 16 == 0 && h / 16 < 39) return v * 40 + h / 16 + 1;
        if (h == 784) begin
            l = (v == 523) ? 0 : v + 1;
            if (l < 480) return l * 40;
        end
        return -1;
    endfunction

    task automatic step(input int v, input int h, input bit rst);
        int fa;
        bit e_ack;
        bit e_clr;
        bit busy_before;
        int a;
        @(negedge clk);
        cur_h = h;
        cur_v = v;
        reset = rst;
        hpos = 10'(h);
        vpos = 10'(v);
        display_on = (h < 640 && v < 480);
        wr_req = w_pend;
        wr_addr = w_addr_q;
        wr_data = w_data_q;
`ifdef FB_CLEAR_EN
        clr_start = clr_pulse;
        clr_data = clr_val;
`endif
        #1;
        fa = rst ? exp_fetch(h, v) : -1;
        e_ack = rst && w_pend && fa < 0 && !exp_busy;
        e_clr = rst && exp_busy && fa < 0;
        check("wr_ack", wr_ack, e_ack);
        if (!rst) begin
            check("we_in_reset", mem_we, 0);
            check("pix_in_reset", pix_out, 0);
        end else if (fa >= 0) begin
            check("slot_addr", int'(mem_addr), fa);
            check("slot_we", mem_we, 0);
        end else if (e_clr) begin
            check("clr_we", mem_we, 1);
            check("clr_addr", int'(mem_addr), exp_ptr);
            check("clr_wdata", mem_wdata, clr_val);
        end else if (e_ack) begin
            check("wr_addr_out", int'(mem_addr), int'(w_addr_q));
            check("wr_we", mem_we, int'(w_addr_q) < FBW);
            if (int'(w_addr_q) < FBW) check("wr_wdata", mem_wdata, w_data_q);
        end else begin
            check("idle_we", mem_we, 0);
            check("idle_addr", int'(mem_addr), 0);
        end
        if (rst && chk_pix && display_on)
            check("pixel", pix_out, int'(fb[v * 40 + h / 16][15 - h % 16]));
        if (rst && !display_on) check("pix_blank", pix_out, 0);
`ifdef FB_CLEAR_EN
        check("clr_busy", clr_busy, exp_busy);
`endif
        busy_before = exp_busy;
        if (e_clr) begin
            fb[exp_ptr] = clr_val;
            exp_ptr++;
            if (exp_ptr == FBW) exp_busy = 0;
        end
        if (e_ack) begin
            if (int'(w_addr_q) < FBW) fb[w_addr_q] = w_data_q;
            w_pend = 0;
        end
        if (!rst) begin
            exp_busy = 0;
        end else if (clr_pulse && !busy_before) begin
            exp_busy = 1;
            exp_ptr = 0;
        end
        clr_pulse = 0;
        if (w_rand && !w_pend && $urandom_range(0, 1) == 1) begin
            case ($urandom_range(0, 7))
                0: a = 19200 + int'($urandom_range(0, 99));
                1: a = int'($urandom_range(0, 19199));
                default: a = int'($urandom_range(0, 319));
            endcase
            w_pend = 1;
            w_addr_q = AW'(a);
            w_data_q = 16'($urandom);
        end
    endtask

    task automatic run_span(input int v, input int h0, input int h1);
        for (int h = h0; h <= h1; h++) step(v, h, 1);
    endtask

    task automatic write_word(input int a, input logic [15:0] d);
        w_pend = 1;
        w_addr_q = AW'(a);
        w_data_q = d;
        for (int i = 0; i < 8 && w_pend; i++) step(500, 100 + i, 1);
        check("write_done", w_pend, 0);
        w_pend = 0;
    endtask

    task automatic check_line(input int v);
        run_span(v == 0 ? 523 : v - 1, 784, 799);
        chk_pix = 1;
        run_span(v, 0, 799);
        chk_pix = 0;
    endtask

    typedef struct {
        int h;
        int v;
        bit req;
        int wa;
        int e_addr;
        bit e_we;
        bit e_ack;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int n;
        int cyc;
        int cv;
        int ch;
        int lv;

        vecs[0]  = '{0,   3,   0, 0,     121,   0, 0};
        vecs[1]  = '{608, 3,   0, 0,     159,   0, 0};
        vecs[2]  = '{784, 3,   0, 0,     160,   0, 0};
        vecs[3]  = '{784, 523, 0, 0,     0,     0, 0};
        vecs[4]  = '{784, 479, 1, 5,     5,     1, 1};
        vecs[5]  = '{32,  10,  1, 77,    403,   0, 0};
        vecs[6]  = '{33,  10,  1, 77,    77,    1, 1};
        vecs[7]  = '{624, 3,   0, 0,     0,     0, 0};
        vecs[8]  = '{0,   480, 0, 0,     0,     0, 0};
        vecs[9]  = '{16,  479, 1, 9,     19162, 0, 0};
        vecs[10] = '{5,   0,   1, 19200, 19200, 0, 1};
        vecs[11] = '{784, 478, 0, 0,     19160, 0, 0};
        vecs[12] = '{799, 3,   1, 19199, 19199, 1, 1};
        vecs[13] = '{640, 3,   0, 0,     0,     0, 0};

        reset = 1'b0;
        hpos = '0;
        vpos = '0;
        display_on = 1'b0;
        wr_req = 1'b0;
        wr_addr = '0;
        wr_data = '0;
`ifdef FB_CLEAR_EN
        clr_start = 1'b0;
        clr_data = '0;
`endif

        // Reset with a pending writer request
        w_pend = 1;
        w_addr_q = AW'(5);
        w_data_q = 16'h1234;
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        w_pend = 0;
        step(0, 1, 1);
        check("pix_reset_state", pix_out, 0);
        check("we_reset_state", mem_we, 0);

        for (int i = 0; i < 14; i++) begin
            w_pend = vecs[i].req;
            w_addr_q = AW'(vecs[i].wa);
            w_data_q = 16'(16'h1000 + i);
            step(vecs[i].v, vecs[i].h, 1);
            check("vec_addr", int'(mem_addr), vecs[i].e_addr);
            check("vec_we", mem_we, vecs[i].e_we);
            check("vec_ack", wr_ack, vecs[i].e_ack);
            w_pend = 0;
        end

        // Pixel order of word 0
        write_word(0, 16'h8001);
        run_span(523, 784, 799);
        chk_pix = 1;
        for (int h = 0; h < 16; h++) begin
            step(0, h, 1);
            check("pix_order", pix_out, (h == 0 || h == 15) ? 1 : 0);
        end
        run_span(0, 16, 799);
        chk_pix = 0;

        // Writer blocked by the slot at hpos 32
        step(10, 31, 1);
        w_pend = 1;
        w_addr_q = AW'(400);
        w_data_q = 16'hBEEF;
        step(10, 32, 1);
        check("ack_at_slot", wr_ack, 0);
        step(10, 33, 1);
        check("ack_after_slot", wr_ack, 1);
        check("we_after_slot", mem_we, 1);
        step(10, 34, 1);
        check("we_one_cycle", mem_we, 0);

        // Reset in the middle of line 0
        for (int i = 0; i < 4; i++) write_word(i, 16'hFFFF);
        run_span(523, 784, 799);
        chk_pix = 1;
        run_span(0, 0, 19);
        chk_pix = 0;
        w_pend = 1;
        w_addr_q = AW'(1000);
        w_data_q = 16'h5555;
        for (int h = 20; h < 23; h++) step(0, h, 0);
        w_pend = 0;
        for (int h = 23; h < 48; h++) begin
            step(0, h, 1);
            check("pix_after_mid_reset", pix_out, 0);
        end
        step(0, 48, 1);
        check("pix_reload", pix_out, 1);

        // Random writes, then whole-line pixel checks
        for (int it = 0; it < 6; it++) begin
            w_rand = 1;
            run_span(int'($urandom_range(0, 523)), 0, 799);
            run_span(int'($urandom_range(0, 523)), 0, 799);
            w_rand = 0;
            for (int i = 0; i < 8 && w_pend; i++) step(500, 200 + i, 1);
            check("drain_done", w_pend, 0);
            w_pend = 0;
            lv = int'($urandom_range(0, 7));
            check_line(lv);
        end

`ifdef FB_CLEAR_EN
        clr_val = 16'hFFFF;
        clr_pulse = 1;
        step(0, 0, 1);
        w_pend = 1;
        w_addr_q = AW'(7);
        w_data_q = 16'h1234;
        n = 0;
        cyc = 0;
        cv = 0;
        ch = 1;
        while (exp_busy && cyc < 25000) begin
            if (cyc == 500) clr_pulse = 1;
            if (cyc == 10000) clr_val = 16'hA5C3;
            step(cv, ch, 1);
            if (mem_we) n++;
            cyc++;
            ch++;
            if (ch == 800) begin
                ch = 0;
                cv = (cv + 1) % 524;
            end
        end
        check("clear_writes", n, 19200);
        check("clear_finished", int'(cyc < 25000), 1);
        step(cv, (ch == 784) ? 785 : ch, 1);
        check("clr_busy_low", clr_busy, 0);
        check("ack_after_clear", wr_ack, 1);
        w_pend = 0;
        check_line(0);
        check_line(479);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
